// File: rtl/n101_reset_req_gen_if.sv
// Request/acknowledge bundle between the reset request generator, its trigger
// sources and the downstream catch-and-sync stage.
interface n101_reset_req_gen_if;
    logic       test_mode;
    logic       sw_req;
    logic       wdog_req;
    logic       dbg_req_async;
    logic       sync_reset_ack;
    logic       cause_clr;
    logic       reset_req;
    logic       busy;
    logic [2:0] cause;

    modport master (
        input  test_mode,
        input  sw_req,
        input  wdog_req,
        input  dbg_req_async,
        input  sync_reset_ack,
        input  cause_clr,
        output reset_req,
        output busy,
        output cause
    );

    modport slave (
        output test_mode,
        output sw_req,
        output wdog_req,
        output dbg_req_async,
        output sync_reset_ack,
        output cause_clr,
        input  reset_req,
        input  busy,
        input  cause
    );
endinterface

// File: rtl/n101_reset_req_gen.sv
// Purpose: merge sw/wdog/debug reset triggers into one stretched, ack-held reset_req with sticky cause.
// Latency: sw/wdog trigger -> reset_req 1 cycle; async debug -> 3 edges; test_mode gates reset_req combinationally.
// Backpressure: reset_req held until sync_reset_ack; triggers during a pulse merge, during cooldown they queue once.
module n101_reset_req_gen #(
    parameter int PULSE_CYCLES    = 16,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic                 clock,
    input  logic                 rst_n,
    n101_reset_req_gen_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LOAD    = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       ack_seen;
    logic       pending;
    logic       req_q;
    logic       busy_q;
    logic [2:0] cause_q;
    logic [2:0] cause_nxt;

    logic       dbg_sync1;
    logic       dbg_sync2;
    logic       dbg_d;
    logic       wdog_d;

    logic       sw_evt;
    logic       wdog_evt;
    logic       dbg_evt;
    logic       trig;
    logic       cnt_zero;

    // Debug request is asynchronous to clock; only the synchronized copy is used.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            dbg_sync1 <= 1'b0;
            dbg_sync2 <= 1'b0;
            dbg_d     <= 1'b0;
            wdog_d    <= 1'b0;
        end else begin
            dbg_sync1 <= bus.dbg_req_async;
            dbg_sync2 <= dbg_sync1;
            dbg_d     <= dbg_sync2;
            wdog_d    <= bus.wdog_req;
        end
    end

    assign sw_evt   = bus.sw_req;
    assign wdog_evt = bus.wdog_req & ~wdog_d;
    assign dbg_evt  = dbg_sync2 & ~dbg_d;
    assign trig     = (sw_evt | wdog_evt | dbg_evt) & ~bus.test_mode;
    assign cnt_zero = (cnt == 8'd0);

    // A new event on the clear edge survives the clear.
    always_comb begin
        cause_nxt = bus.cause_clr ? 3'b000 : cause_q;
        cause_nxt = cause_nxt | {dbg_evt, wdog_evt, sw_evt};
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= 3'b000;
        end else begin
            cause_q <= cause_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            ack_seen <= 1'b0;
            pending  <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.test_mode) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            ack_seen <= 1'b0;
            pending  <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state    <= ASSERT;
                        cnt      <= PULSE_LOAD;
                        ack_seen <= 1'b0;
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ASSERT: begin
                    // Merged triggers only touch cause; the pulse is never extended by them.
                    if (bus.sync_reset_ack) begin
                        ack_seen <= 1'b1;
                    end
                    if (cnt_zero && (ack_seen || bus.sync_reset_ack)) begin
                        state  <= COOLDOWN;
                        cnt    <= COOLDOWN_LOAD;
                        req_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end else if (!cnt_zero) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                COOLDOWN: begin
                    if (cnt_zero) begin
                        if (pending || trig) begin
                            state    <= ASSERT;
                            cnt      <= PULSE_LOAD;
                            ack_seen <= 1'b0;
                            pending  <= 1'b0;
                            req_q    <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (trig) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= 8'd0;
                    ack_seen <= 1'b0;
                    pending  <= 1'b0;
                    req_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reset_req = req_q & ~bus.test_mode;
    assign bus.busy      = busy_q;
    assign bus.cause     = cause_q;

    a_req_implies_busy : assert property (@(posedge clock) disable iff (!rst_n)
        req_q |-> busy_q);
    a_req_matches_state : assert property (@(posedge clock) disable iff (!rst_n)
        req_q == (state == ASSERT));

endmodule

// File: tb/tb_n101_reset_req_gen.sv
// Randomized and directed bench for n101_reset_req_gen against a cycle-count reference model.
module tb_n101_reset_req_gen;
    localparam int P = 16;
    localparam int C = 8;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    n101_reset_req_gen_if bus ();

    n101_reset_req_gen #(.PULSE_CYCLES(P), .COOLDOWN_CYCLES(C)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 request high, 2 cooldown; counts cycles spent in a phase.
    int       m_phase;
    int       m_hi;
    int       m_lo;
    bit       m_ackd;
    bit       m_pend;
    bit [2:0] m_cause;
    bit       h1, h2, h3;
    bit       m_wd_prev;

    // Observation bookkeeping for directed checks.
    int step_idx, obs_hi, obs_rises, obs_busy, first_hi, lo_run, last_gap;
    bit prev_req;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_hi = 0; m_lo = 0; m_ackd = 0; m_pend = 0;
        m_cause = 3'b000; h1 = 0; h2 = 0; h3 = 0; m_wd_prev = 0;
    endtask

    task automatic model_edge(input bit sw, input bit wd, input bit dbg, input bit ack,
                              input bit clr, input bit tm);
        bit e_sw, e_wd, e_dbg, trig;
        e_sw  = sw;
        e_wd  = wd && !m_wd_prev;
        e_dbg = h2 && !h3;          // level seen two edges ago, low three edges ago
        h3 = h2; h2 = h1; h1 = dbg;
        m_wd_prev = wd;
        if (clr) m_cause = 3'b000;
        m_cause = m_cause | {e_dbg, e_wd, e_sw};
        trig = (e_sw || e_wd || e_dbg) && !tm;
        if (tm) begin
            m_phase = 0; m_pend = 0; m_ackd = 0;
        end else begin
            case (m_phase)
                0: if (trig) begin m_phase = 1; m_hi = 1; m_ackd = 0; end
                1: begin
                    if (m_hi >= P && (m_ackd || ack)) begin
                        m_phase = 2; m_lo = 1;
                    end else begin
                        m_hi++;
                        if (ack) m_ackd = 1;
                    end
                end
                default: begin
                    if (m_lo >= C) begin
                        if (m_pend || trig) begin
                            m_phase = 1; m_hi = 1; m_ackd = 0; m_pend = 0;
                        end else begin
                            m_phase = 0;
                        end
                    end else begin
                        m_lo++;
                        if (trig) m_pend = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic clear_obs();
        step_idx = 0; obs_hi = 0; obs_rises = 0; obs_busy = 0;
        first_hi = -1; lo_run = 0; last_gap = -1; prev_req = bus.reset_req;
    endtask

    task automatic step(input bit sw, input bit wd, input bit dbg, input bit ack,
                        input bit clr, input bit tm);
        @(negedge clock);
        bus.sw_req = sw; bus.wdog_req = wd; bus.dbg_req_async = dbg;
        bus.sync_reset_ack = ack; bus.cause_clr = clr; bus.test_mode = tm;
        #1;
        check_val("req", {31'd0, bus.reset_req}, {31'd0, (m_phase == 1) && !tm});
        check_val("busy", {31'd0, bus.busy}, {31'd0, m_phase != 0});
        check_val("cause", {29'd0, bus.cause}, {29'd0, m_cause});
        if (bus.reset_req) begin
            obs_hi++;
            if (!prev_req) begin
                obs_rises++;
                if (first_hi < 0) first_hi = step_idx;
                last_gap = lo_run;
            end
            lo_run = 0;
        end else begin
            lo_run++;
        end
        if (bus.busy) obs_busy++;
        prev_req = bus.reset_req;
        step_idx++;
        @(posedge clock);
        model_edge(sw, wd, dbg, ack, clr, tm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit wd_l, dbg_l, ack_l;
        bus.sw_req = 0; bus.wdog_req = 0; bus.dbg_req_async = 0;
        bus.sync_reset_ack = 0; bus.cause_clr = 0; bus.test_mode = 0;
        model_reset();
        #23;
        check_val("rst_req", {31'd0, bus.reset_req}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_cause", {29'd0, bus.cause}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        clear_obs();
        idle(3);

        // Power-on software reset with ack arriving early.
        clear_obs();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 35; i++) step(0, 0, 0, 1, 0, 0);
        check_val("sw_width", obs_hi, P);
        check_val("sw_busy", obs_busy, P + C);
        check_val("sw_cause", {29'd0, bus.cause}, 32'b001);

        // Late ack: first ack in the 31st high cycle.
        step(0, 0, 0, 0, 1, 0);
        clear_obs();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, 0);
        check_val("late_width", obs_hi, 31);
        idle(5);

        // Debug level held: single pulse, rising on the third edge.
        step(0, 0, 0, 0, 1, 0);
        clear_obs();
        for (int i = 0; i < 45; i++) step(0, 0, 1, 1, 0, 0);
        check_val("dbg_first", first_hi, 3);
        check_val("dbg_rises", obs_rises, 1);
        check_val("dbg_width", obs_hi, P);
        check_val("dbg_cause", {29'd0, bus.cause}, 32'b100);
        idle(4);

        // Watchdog rising during an active pulse merges.
        step(0, 0, 0, 0, 1, 0);
        clear_obs();
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 1, 0, 0);
        check_val("merge_width", obs_hi, P);
        check_val("merge_rises", obs_rises, 1);
        check_val("merge_cause", {29'd0, bus.cause}, 32'b011);
        idle(4);

        // Software request during cooldown queues a second pulse.
        clear_obs();
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 0, 0);
        check_val("pend_rises", obs_rises, 2);
        check_val("pend_gap", last_gap, C);
        check_val("pend_width", obs_hi, 2 * P);

        // Clear and watchdog edge on the same cycle.
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 0, 0);
        check_val("clr_wdog", {29'd0, bus.cause}, 32'b010);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0, 0);

        // test_mode aborts a pulse and blocks triggers while still recording cause.
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        #2;
        check_val("tm_busy", {31'd0, bus.busy}, 32'd0);
        step(0, 0, 0, 0, 1, 1);
        clear_obs();
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        idle(5);
        check_val("tm_rises", obs_rises, 0);
        check_val("tm_cause", {29'd0, bus.cause}, 32'b001);

        // Randomized traffic.
        wd_l = 0; dbg_l = 0; ack_l = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) wd_l = ~wd_l;
            if ($urandom_range(0, 24) == 0) dbg_l = ~dbg_l;
            if ($urandom_range(0, 5) == 0) ack_l = ~ack_l;
            step($urandom_range(0, 29) == 0, wd_l, dbg_l, ack_l,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) < 2);
        end

        // Power-on reset mid-pulse aborts asynchronously and loses cause.
        idle(40);
        step(1, 0, 0, 0, 0, 0);
        idle(4);
        @(negedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_req", {31'd0, bus.reset_req}, 32'd0);
        check_val("arst_cause", {29'd0, bus.cause}, 32'd0);
        model_reset();
        @(negedge clock);
        check_val("arst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
